// File: rtl/hyperspace_pkg.sv
// Shared constants for the hyperspace streaming core: pad map, widths and FSM states.
// io_in[IN_DATA_LSB +: 8] carries the input byte bit-reversed (pad 37 is the data LSB).
package hyperspace_pkg;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned IO_N  = 38;

  localparam int unsigned IN_DATA_LSB = 30;
  localparam int unsigned IN_LAST     = 29;
  localparam int unsigned IN_VALID    = 28;
  localparam int unsigned IN_READY    = 27;
  localparam int unsigned OUT_READY   = 18;
  localparam int unsigned OUT_VALID   = 17;
  localparam int unsigned OUT_LAST    = 16;

  // Outputs on bit 27 and bits 17:0; everything else is an input pad.
  localparam logic [IO_N-1:0] OEB_PATTERN = 38'h3F_F7FC_0000;

  typedef enum logic {COLLECT, EMIT} state_e;

endpackage

// File: rtl/hyperspace_haar4.sv
// Combinational 4-point Haar-type reduction: unsigned bytes in, 16-bit two's complement out.
module hyperspace_haar4
  import hyperspace_pkg::*;
(
  input  logic [IN_W-1:0]  x0,
  input  logic [IN_W-1:0]  x1,
  input  logic [IN_W-1:0]  x2,
  input  logic [IN_W-1:0]  x3,
  output logic [OUT_W-1:0] y0,
  output logic [OUT_W-1:0] y1,
  output logic [OUT_W-1:0] y2
);

  logic [OUT_W-1:0] e0, e1, e2, e3;

  assign e0 = {{(OUT_W-IN_W){1'b0}}, x0};
  assign e1 = {{(OUT_W-IN_W){1'b0}}, x1};
  assign e2 = {{(OUT_W-IN_W){1'b0}}, x2};
  assign e3 = {{(OUT_W-IN_W){1'b0}}, x3};

  // Modulo-2^16 subtraction gives the two's complement result directly.
  assign y0 = e0 + e1 + e2 + e3;
  assign y1 = (e0 + e1) - (e2 + e3);
  assign y2 = (e0 + e2) - (e1 + e3);

endmodule

// File: rtl/caravel_hyperspace.sv
// Caravel user-project streaming core: collects 4-byte blocks from the pads and emits three
// Haar coefficients per block on a valid/ready output port.
module caravel_hyperspace
  import hyperspace_pkg::*;
(
  input  logic            clock,
  input  logic            RSTB,
  input  logic [IO_N-1:0] io_in,
  output logic [IO_N-1:0] io_out,
  output logic [IO_N-1:0] io_oeb
);

  logic [IN_W-1:0] in_data;
  logic            in_last, in_valid, out_ready, in_ready;

  for (genvar k = 0; k < IN_W; k++) begin : g_unpack
    assign in_data[IN_W-1-k] = io_in[IN_DATA_LSB+k];
  end
  assign in_last   = io_in[IN_LAST];
  assign in_valid  = io_in[IN_VALID];
  assign out_ready = io_in[OUT_READY];

  logic unused_pads;
  assign unused_pads = ^{io_in[IN_READY:OUT_READY+1], io_in[OUT_READY-1:0]};

  state_e                 state_q;
  logic [1:0]             cnt_q, idx_q;
  logic [3:0][IN_W-1:0]   x_q, x_new;
  logic [2:0][OUT_W-1:0]  y_q;
  logic                   lastf_q, in_ready_q, out_valid_q, out_last_q;
  logic [OUT_W-1:0]       out_data_q;
  logic [OUT_W-1:0]       y0, y1, y2;

  // Unwritten slots stay zero because x_q is cleared after every block.
  always_comb begin
    x_new        = x_q;
    x_new[cnt_q] = in_data;
  end

  hyperspace_haar4 u_haar4 (
    .x0 (x_new[0]),
    .x1 (x_new[1]),
    .x2 (x_new[2]),
    .x3 (x_new[3]),
    .y0 (y0),
    .y1 (y1),
    .y2 (y2)
  );

  always_ff @(posedge clock) begin
    if (RSTB) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      lastf_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            lastf_q <= lastf_q | in_last;
            if (cnt_q == 2'd3 || in_last) begin
              y_q         <= {y2, y1, y0};
              out_data_q  <= y0;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b0;
              idx_q       <= '0;
              cnt_q       <= '0;
              x_q         <= '0;
              state_q     <= EMIT;
            end else begin
              x_q   <= x_new;
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        EMIT: begin
          if (out_ready && out_valid_q) begin
            if (idx_q == 2'd2) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              in_ready_q  <= 1'b1;
              lastf_q     <= 1'b0;
              idx_q       <= '0;
              state_q     <= COLLECT;
            end else begin
              idx_q      <= idx_q + 2'd1;
              out_data_q <= y_q[idx_q + 2'd1];
              out_last_q <= lastf_q && (idx_q == 2'd1);
            end
          end
        end
      endcase
    end
  end

  // Forced low combinationally so in_ready never shows 1 while reset is held.
  assign in_ready = in_ready_q & ~RSTB;

  always_comb begin
    io_out             = '0;
    io_out[IN_READY]   = in_ready;
    io_out[OUT_VALID]  = out_valid_q;
    io_out[OUT_LAST]   = out_last_q;
    io_out[OUT_W-1:0]  = out_data_q;
  end

  assign io_oeb = OEB_PATTERN;

endmodule

// File: tb/tb_caravel_hyperspace.sv
// Scoreboard bench for caravel_hyperspace: directed blocks, backpressure, resets and a random frame.
module tb_caravel_hyperspace;

  logic        clock = 1'b0;
  logic        RSTB  = 1'b1;
  logic [37:0] io_in, io_out, io_oeb;
  logic [7:0]  in_byte  = '0;
  logic        in_last  = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [37:0] junk = '0;

  localparam logic [37:0] OEB_EXP  = 38'h3F_F7FC_0000;
  localparam logic [37:0] OUT_MASK = 38'h00_0803_FFFF;

  always #5 clock = ~clock;

  caravel_hyperspace dut (
    .clock  (clock),
    .RSTB   (RSTB),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  always_comb begin
    io_in = junk;
    for (int k = 0; k < 8; k++) io_in[30+k] = in_byte[7-k];
    io_in[29] = in_last;
    io_in[28] = in_valid;
    io_in[18] = out_ready;
  end

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] blk[$];
  int checks = 0, failures = 0;
  int ready_mode = 1;  // 0 hold low, 1 hold high, 2 random
  bit model_on = 1'b0;
  int words_seen = 0, lasts_seen = 0, last_idx = -1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  function automatic void expect_word(input logic [15:0] d, input logic l);
    exp_q.push_back('{data: d, last: l});
  endfunction

  // Reference: pad short block with zeros, apply the three sum/difference formulas.
  function automatic void model_block(input logic last);
    int x[4];
    int s0, s1, s2;
    for (int i = 0; i < 4; i++) x[i] = (i < blk.size()) ? int'(blk[i]) : 0;
    s0 = x[0] + x[1] + x[2] + x[3];
    s1 = (x[0] + x[1]) - (x[2] + x[3]);
    s2 = (x[0] + x[2]) - (x[1] + x[3]);
    expect_word(16'(s0), 1'b0);
    expect_word(16'(s1), 1'b0);
    expect_word(16'(s2), last);
    blk.delete();
  endfunction

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    in_byte  = b;
    in_last  = last;
    in_valid = 1'b1;
    junk     = {$urandom, $urandom};
    while (!io_out[27] && n <= 200) begin
      @(negedge clock);
      n++;
    end
    if (n > 200) begin
      fail_now("send_timeout");
    end else begin
      @(posedge clock);
      if (model_on) begin
        blk.push_back(b);
        if (last || blk.size() == 4) model_block(last);
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    RSTB     = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    blk.delete();
    repeat (cycles) @(negedge clock);
    check("rst_in_ready", io_out[27], 1'b0);
    check("rst_out_valid", io_out[17], 1'b0);
    check("rst_io_out", io_out, '0);
    check("rst_io_oeb", io_oeb, OEB_EXP);
    RSTB = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", io_out[27], 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || io_out[17]) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) fail_now("drain_timeout");
  endtask

  // Monitor: picks out_ready for the coming edge and scores any word that will transfer.
  initial begin
    logic        held = 1'b0;
    logic [16:0] held_val = '0;
    word_t       e;
    forever begin
      @(negedge clock);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (!RSTB && io_out[17]) begin
        check("in_ready_in_emit", io_out[27], 1'b0);
        check("unused_out_zero", io_out & ~OUT_MASK, '0);
        if (held) check("hold_stable", io_out[16:0], held_val);
        if (out_ready) begin
          if (io_out[16]) begin
            lasts_seen++;
            last_idx = words_seen;
          end
          words_seen++;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_word");
          end else begin
            e = exp_q.pop_front();
            check("word_data", io_out[15:0], e.data);
            check("word_last", io_out[16], e.last);
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_val = io_out[16:0];
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    @(negedge clock);
    do_reset(10);

    // Directed blocks with constant expectations.
    expect_word(16'h000A, 1'b0); expect_word(16'h0004, 1'b0); expect_word(16'h0002, 1'b0);
    send(8'h04, 1'b0); send(8'h03, 1'b0); send(8'h02, 1'b0); send(8'h01, 1'b0);
    drain();

    expect_word(16'h01FE, 1'b0); expect_word(16'h0000, 1'b0); expect_word(16'hFE02, 1'b0);
    send(8'h00, 1'b0); send(8'hFF, 1'b0); send(8'h00, 1'b0); send(8'hFF, 1'b0);
    drain();

    // Backpressure: first word must sit frozen for 5 stalled cycles.
    ready_mode = 0;
    expect_word(16'h00AA, 1'b0); expect_word(16'hFFBC, 1'b0); expect_word(16'hFFDE, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    repeat (5) @(negedge clock);
    check("stall_data", io_out[15:0], 16'h00AA);
    check("stall_valid", io_out[17], 1'b1);
    ready_mode = 1;
    drain();

    // Short block closed by in_last on the second byte.
    expect_word(16'h0030, 1'b0); expect_word(16'h0030, 1'b0); expect_word(16'hFFF0, 1'b1);
    send(8'h10, 1'b0); send(8'h20, 1'b1);
    drain();

    // Reset mid-EMIT, then mid-block: nothing pending may survive.
    ready_mode = 0;
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
    repeat (2) @(negedge clock);
    do_reset(3);
    ready_mode = 1;
    send(8'h99, 1'b0); send(8'hAA, 1'b0);
    do_reset(2);
    expect_word(16'h000A, 1'b0); expect_word(16'hFFFC, 1'b0); expect_word(16'hFFFE, 1'b0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    drain();

    // Random bytes with random in_last and random output stalls.
    model_on   = 1'b1;
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clock);
      send(8'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    if (blk.size() != 0) send(8'($urandom), 1'b1);
    drain();

    // Full 2048-byte frame, in_last only on the final byte.
    base       = words_seen;
    lasts_seen = 0;
    for (int i = 0; i < 2048; i++) begin
      if ($urandom_range(0, 5) == 0) @(negedge clock);
      send(8'($urandom), 1'(i == 2047));
    end
    drain();
    check("frame_words", 64'(words_seen - base), 64'd1536);
    check("frame_lasts", 64'(lasts_seen), 64'd1);
    check("frame_last_idx", 64'(last_idx - base), 64'd1535);
    check("final_io_oeb", io_oeb, OEB_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
